mem_req_responder: RTL

Memory-side responder for the requestor/arbiter interface: the far end that receives the single arbitrated memory request stream. It owns a small synchronous storage array and performs read or write per accepted request. It returns one response per request, routed back to the originating requestor's response channel by request id. At most one request is in flight; this is a single-outstanding, non-pipelined design.

---
 rtl/mem_resp_pkg.sv | 28 ++
 rtl/mem_resp_store.sv | 40 ++++
 rtl/mem_req_responder.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the single-outstanding memory responder.
package mem_resp_pkg;

  localparam int unsigned DefNReq  = 4;
  localparam int unsigned DefAddrW = 8;
  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefDepth = 192;
  localparam int unsigned DefIdW   = $clog2(DefNReq);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  // Request bundle at the package default widths.
  typedef struct packed {
    logic [DefIdW-1:0]   id;
    logic [DefAddrW-1:0] addr;
    logic                wen;
    logic [DefDataW-1:0] data;
  } req_t;

  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/mem_resp_store.sv
// Single-port DEPTH x DATA_W storage with registered read; out-of-range writes are
// dropped and out-of-range reads return zero.
module mem_resp_store
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              rd,
  input  logic              clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;

  assign in_range = addr_in_range(32'(addr), DEPTH);

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we && in_range) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (rd) begin
      rdata <= (clr || !in_range) ? '0 : mem[addr];
    end
  end

endmodule

// File: rtl/mem_req_responder.sv
// Memory-side responder: accepts one request at a time and routes the response back by id.
// Optional MEM_RESP_ERR_EN adds io_resp_bits_err flagging out-of-range addresses.
module mem_req_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned N_REQ  = DefNReq,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth,
  localparam int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_req_valid,
  output logic              io_req_ready,
  input  logic [ID_W-1:0]   io_req_bits_id,
  input  logic [ADDR_W-1:0] io_req_bits_addr,
  input  logic              io_req_bits_wen,
  input  logic [DATA_W-1:0] io_req_bits_data,
  output logic [N_REQ-1:0]  io_resp_valid,
  input  logic [N_REQ-1:0]  io_resp_ready,
  output logic [DATA_W-1:0] io_resp_bits_data
`ifdef MEM_RESP_ERR_EN
  ,
  output logic              io_resp_bits_err
`endif
);

  state_e            state_q;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [N_REQ-1:0]  resp_valid_q;
  logic              req_ready_q;

  logic [ADDR_W-1:0] store_addr;
  logic              store_we;
  logic              store_rd;
  logic              id_bad;

  // The write lands on the accept edge, so the store sees the live request address in idle.
  assign store_addr = (state_q == StIdle) ? io_req_bits_addr : addr_q;
  assign store_we   = (state_q == StIdle) && io_req_valid && io_req_bits_wen;
  assign store_rd   = (state_q == StAccess);
  assign id_bad     = 32'(id_q) >= N_REQ;

  assign io_req_ready  = req_ready_q;
  assign io_resp_valid = resp_valid_q;

  mem_resp_store #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_store (
    .clk  (clk),
    .reset(reset),
    .we   (store_we),
    .rd   (store_rd),
    .clr  (wen_q),
    .addr (store_addr),
    .wdata(io_req_bits_data),
    .rdata(io_resp_bits_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      id_q         <= '0;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      resp_valid_q <= '0;
      req_ready_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (io_req_valid) begin
            id_q        <= io_req_bits_id;
            addr_q      <= io_req_bits_addr;
            wen_q       <= io_req_bits_wen;
            req_ready_q <= 1'b0;
            state_q     <= StAccess;
          end
        end
        StAccess: begin
          if (id_bad) begin
            req_ready_q <= 1'b1;
            state_q     <= StIdle;
          end else begin
            resp_valid_q <= N_REQ'(1) << id_q;
            state_q      <= StResp;
          end
        end
        StResp: begin
          // Only the addressed channel's ready completes the handshake.
          if (io_resp_ready[id_q]) begin
            resp_valid_q <= '0;
            req_ready_q  <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: begin
          resp_valid_q <= '0;
          req_ready_q  <= 1'b1;
          state_q      <= StIdle;
        end
      endcase
    end
  end

`ifdef MEM_RESP_ERR_EN
  logic err_q;

  assign io_resp_bits_err = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (state_q == StAccess) begin
      err_q <= !addr_in_range(32'(addr_q), DEPTH);
    end else if (state_q == StResp && io_resp_ready[id_q]) begin
      err_q <= 1'b0;
    end
  end
`endif

endmodule
